gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
Parametrised up/down Gray-code counter. Generalises the fixed 4-bit Gray counter in width, direction, load and wrap/saturate mode. Provides registered Gray and binary outputs plus terminal-count flags. Used wherever a multi-bit count crosses a clock domain, such as FIFO pointers and position counters.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..32).
WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at the end values.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
en  in  1  count enable; one step per cycle while high
up_dn  in  1  direction when en=1: 1 = up, 0 = down
load  in  1  load request
load_gray  in  WIDTH  Gray-coded value to load
gray_out  out  WIDTH  registered Gray count
bin_out  out  WIDTH  registered binary equivalent of gray_out
event  out  1  one-cycle pulse on wrap (WRAP=1) or on a blocked step (WRAP=0)
at_max  out  1  bin_out == 2^WIDTH-1 (decoded from registers)
at_min  out  1  bin_out == 0 (decoded from registers)

Behaviour:
- Interface: reset is synchronous and active-high; clock is clock.
- Reset values: bin_out=0, gray_out=0, event=0. As a result at_min=1 and at_max=0.
- Priority on each rising edge: reset > load > en > hold.
- Reset mid-count clears all state at that edge. Any load or en sampled at that edge is ignored.
- Internal state is one binary register. gray_out is registered as next_bin ^ (next_bin >> 1), so gray_out and bin_out are always mutually consistent in the same cycle.
- Latency: a step or load sampled at edge N is visible on the outputs immediately after edge N.
- Load:
  - Convert load_gray to binary: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i], for i from W-2 down to 0.
  - gray_out takes load_gray and bin_out takes b.
  - event=0 on a load cycle, even when en=1.
- Step, WRAP=1:
  - Up: bin+1 mod 2^WIDTH. Down: bin-1 mod 2^WIDTH.
  - event=1 for exactly one cycle when the step goes max->0 (up) or 0->max (down). Otherwise event=0.
- Step, WRAP=0:
  - Up at max and down at 0 leave the state unchanged and set event=1 for that cycle.
  - All other steps behave as in WRAP=1, with event=0.
- When en=0 and load=0: state holds and event=0.
- up_dn is ignored when en=0.
- Every step (not load, not reset) changes exactly one gray_out bit. A blocked saturate step changes no bits.
- at_max and at_min are combinational decodes of the registered bin_out only. They have no input-to-output path.

Optional Feature:
Macro GRAY_STEP_CHECK_EN.
- With the macro defined:
  - Adds output port step_err (1 bit, reset 0).
  - The block keeps a registered copy of the previous gray_out and a registered "last update was a step" flag.
  - step_err is a registered, sticky bit. It goes to 1 when the popcount of (gray_out ^ prev_gray) after a step is not 1, excluding blocked saturate steps, which must have popcount 0.
  - Only reset clears step_err.
- Without the macro: no step_err port and no checker logic. Counter behaviour is identical in both builds.

Test Plan:
- WIDTH=4, WRAP=1: reset then 16 cycles of en=1, up_dn=1 -> gray_out follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000. event=1 only in the cycle gray_out returns to 0000. at_max=1 while bin_out=15.
- WIDTH=4, WRAP=1: from reset, one step with up_dn=0 -> bin_out=15, gray_out=1000, event=1 for one cycle. Next step down -> bin_out=14, gray_out=1001, event=0.
- Load: load=1, en=1, load_gray=1101 -> next cycle gray_out=1101, bin_out=1001 (9), event=0. Then one up step -> gray_out=1111, bin_out=10.
- WIDTH=4, WRAP=0: load 1000 (bin 15), then 3 up steps -> state stays 15 with event=1 each cycle. One down step -> bin 14, event=0. Repeat the check at 0 going down.
- Reset mid-operation: counting up at bin 6, assert reset together with load=1 -> next cycle bin_out=0, gray_out=0, event=0. Load is ignored.
- WIDTH=8 with GRAY_STEP_CHECK_EN: 600 random en/up_dn/load cycles, checked against a binary reference model -> gray_out == bin ^ (bin >> 1) every cycle and step_err stays 0. Forcing gray_out to flip two bits -> step_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/gray_counter_param_if.sv
// Signal bundle for gray_counter_param.
// Optional macro GRAY_STEP_CHECK_EN adds the step_err status line.
// The event pulse is carried as event_o because "event" is a reserved word.
interface gray_counter_param_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] gray_out;
   logic [WIDTH-1:0] bin_out;
   logic             event_o;
   logic             at_max;
   logic             at_min;
`ifdef GRAY_STEP_CHECK_EN
   logic             step_err;
`endif

   modport master (
      output en, up_dn, load, load_gray,
      input  gray_out, bin_out, event_o, at_max, at_min
`ifdef GRAY_STEP_CHECK_EN
      , input step_err
`endif
   );

   modport slave (
      input  en, up_dn, load, load_gray,
      output gray_out, bin_out, event_o, at_max, at_min
`ifdef GRAY_STEP_CHECK_EN
      , output step_err
`endif
   );
endinterface

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with load and wrap/saturate mode.
// State is a single binary register; the Gray output register is loaded from
// the encoded next binary value so both outputs always agree.
// Optional macro GRAY_STEP_CHECK_EN adds a sticky single-bit-step checker.
module gray_counter_param #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned WRAP  = 1
) (
   input logic                 clock,
   input logic                 reset,
   gray_counter_param_if.slave cnt
);

   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             event_q, event_d;
   logic             step_req;
   logic             end_hit;

   // Prefix XOR from the MSB down: bin[k] = ^gray[WIDTH-1:k]
   function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b = g;
      for (int unsigned i = 1; i < WIDTH; i++) begin
         b = b ^ (g >> i);
      end
      return b;
   endfunction

   // Next-state selection: load beats step, step beats hold
   always_comb begin
      bin_d    = bin_q;
      event_d  = 1'b0;
      step_req = !cnt.load && cnt.en;
      end_hit  = cnt.up_dn ? (bin_q == '1) : (bin_q == '0);
      if (cnt.load) begin
         bin_d = gray_to_bin(cnt.load_gray);
      end else if (cnt.en) begin
         if (end_hit) begin
            event_d = 1'b1;
            if (WRAP != 0) begin
               bin_d = cnt.up_dn ? '0 : '1;
            end
         end else if (cnt.up_dn) begin
            bin_d = bin_q + WIDTH'(1);
         end else begin
            bin_d = bin_q - WIDTH'(1);
         end
      end
      gray_d = bin_d ^ (bin_d >> 1);
   end

   // Counter registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         bin_q   <= '0;
         gray_q  <= '0;
         event_q <= 1'b0;
      end else begin
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         event_q <= event_d;
      end
   end

   assign cnt.gray_out = gray_q;
   assign cnt.bin_out  = bin_q;
   assign cnt.event_o  = event_q;
   assign cnt.at_max   = (bin_q == '1);
   assign cnt.at_min   = (bin_q == '0);

`ifdef GRAY_STEP_CHECK_EN
   logic [WIDTH-1:0] prev_gray_q;
   logic             was_step_q;
   logic             was_blocked_q;
   logic             step_err_q, step_err_d;
   logic             is_step;
   logic             is_blocked;
   logic [WIDTH-1:0] flip;

   // Classify this cycle's update and judge the previous one
   always_comb begin
      is_blocked = step_req && end_hit && (WRAP == 0);
      is_step    = step_req && !is_blocked;
      flip       = gray_q ^ prev_gray_q;
      step_err_d = step_err_q;
      if (was_step_q && ($countones(flip) != 1)) begin
         step_err_d = 1'b1;
      end
      if (was_blocked_q && ($countones(flip) != 0)) begin
         step_err_d = 1'b1;
      end
   end

   // Checker history and sticky error flag
   always_ff @(posedge clock) begin
      if (reset) begin
         prev_gray_q   <= '0;
         was_step_q    <= 1'b0;
         was_blocked_q <= 1'b0;
         step_err_q    <= 1'b0;
      end else begin
         prev_gray_q   <= gray_q;
         was_step_q    <= is_step;
         was_blocked_q <= is_blocked;
         step_err_q    <= step_err_d;
      end
   end

   assign cnt.step_err = step_err_q;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Directed bench for gray_counter_param: wrap and saturate 4-bit instances
// plus an 8-bit instance driven by a random sequence against a binary model.
// With GRAY_STEP_CHECK_EN defined the step_err flag is also exercised.
module tb_gray_counter_param;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   gray_counter_param_if #(.WIDTH(4)) if_a ();
   gray_counter_param_if #(.WIDTH(4)) if_b ();
   gray_counter_param_if #(.WIDTH(8)) if_c ();

   gray_counter_param #(.WIDTH(4), .WRAP(1)) dut_a (.clock(clock), .reset(reset), .cnt(if_a));
   gray_counter_param #(.WIDTH(4), .WRAP(0)) dut_b (.clock(clock), .reset(reset), .cnt(if_b));
   gray_counter_param #(.WIDTH(8), .WRAP(1)) dut_c (.clock(clock), .reset(reset), .cnt(if_c));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_all();
      if_a.en = 0; if_a.up_dn = 0; if_a.load = 0; if_a.load_gray = '0;
      if_b.en = 0; if_b.up_dn = 0; if_b.load = 0; if_b.load_gray = '0;
      if_c.en = 0; if_c.up_dn = 0; if_c.load = 0; if_c.load_gray = '0;
   endtask

   function automatic logic [7:0] g2b8(input logic [7:0] g);
      logic [7:0] b;
      b[7] = g[7];
      for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic test_reset();
      if_a.en = 1; if_a.up_dn = 1; if_a.load = 1; if_a.load_gray = 4'b1010;
      reset = 1;
      tick();
      checks++;
      if ({if_a.gray_out, if_a.bin_out, if_a.event_o, if_a.at_max, if_a.at_min} !== {4'h0, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL reset: gray=%b bin=%0d ev=%b max=%b min=%b, need 0000 0 0 0 1",
                  if_a.gray_out, if_a.bin_out, if_a.event_o, if_a.at_max, if_a.at_min);
      end
      idle_all();
      reset = 0;
   endtask

   task automatic test_count_up();
      logic [3:0] gseq [0:16];
      gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
      if_a.en = 1; if_a.up_dn = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (if_a.gray_out !== gseq[i] || if_a.bin_out !== 4'(i % 16) || if_a.event_o !== (i == 16) ||
             if_a.at_max !== (i == 15) || if_a.at_min !== (i == 16)) begin
            failures++;
            $display("FAIL count_up[%0d]: gray=%b bin=%0d ev=%b max=%b min=%b, need gray=%b bin=%0d ev=%b max=%b min=%b",
                     i, if_a.gray_out, if_a.bin_out, if_a.event_o, if_a.at_max, if_a.at_min,
                     gseq[i], i % 16, (i == 16), (i == 15), (i == 16));
         end
      end
      if_a.en = 0;
      tick();
      checks++;
      if (if_a.event_o !== 1'b0 || if_a.bin_out !== 4'd0) begin
         failures++;
         $display("FAIL count_up_hold: bin=%0d ev=%b, need bin=0 ev=0", if_a.bin_out, if_a.event_o);
      end
   endtask

   task automatic test_down_wrap();
      reset = 1; tick(); reset = 0;
      if_a.en = 1; if_a.up_dn = 0;
      tick();
      checks++;
      if (if_a.bin_out !== 4'd15 || if_a.gray_out !== 4'b1000 || if_a.event_o !== 1'b1 || if_a.at_max !== 1'b1) begin
         failures++;
         $display("FAIL down_wrap: bin=%0d gray=%b ev=%b max=%b, need 15 1000 1 1",
                  if_a.bin_out, if_a.gray_out, if_a.event_o, if_a.at_max);
      end
      tick();
      checks++;
      if (if_a.bin_out !== 4'd14 || if_a.gray_out !== 4'b1001 || if_a.event_o !== 1'b0) begin
         failures++;
         $display("FAIL down_next: bin=%0d gray=%b ev=%b, need 14 1001 0", if_a.bin_out, if_a.gray_out, if_a.event_o);
      end
      if_a.en = 0;
   endtask

   task automatic test_load();
      if_a.load = 1; if_a.en = 1; if_a.up_dn = 1; if_a.load_gray = 4'b1101;
      tick();
      checks++;
      if (if_a.gray_out !== 4'b1101 || if_a.bin_out !== 4'd9 || if_a.event_o !== 1'b0) begin
         failures++;
         $display("FAIL load: gray=%b bin=%0d ev=%b, need 1101 9 0", if_a.gray_out, if_a.bin_out, if_a.event_o);
      end
      if_a.load = 0;
      tick();
      checks++;
      if (if_a.gray_out !== 4'b1111 || if_a.bin_out !== 4'd10) begin
         failures++;
         $display("FAIL load_step: gray=%b bin=%0d, need 1111 10", if_a.gray_out, if_a.bin_out);
      end
      if_a.en = 0; if_a.up_dn = 0;
      tick();
      checks++;
      if (if_a.gray_out !== 4'b1111 || if_a.bin_out !== 4'd10 || if_a.event_o !== 1'b0) begin
         failures++;
         $display("FAIL hold: gray=%b bin=%0d ev=%b, need 1111 10 0", if_a.gray_out, if_a.bin_out, if_a.event_o);
      end
   endtask

   task automatic test_saturate();
      if_b.load = 1; if_b.load_gray = 4'b1000;
      tick();
      if_b.load = 0; if_b.en = 1; if_b.up_dn = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (if_b.bin_out !== 4'd15 || if_b.gray_out !== 4'b1000 || if_b.event_o !== 1'b1) begin
            failures++;
            $display("FAIL sat_max[%0d]: bin=%0d gray=%b ev=%b, need 15 1000 1", i, if_b.bin_out, if_b.gray_out, if_b.event_o);
         end
      end
      if_b.up_dn = 0;
      tick();
      checks++;
      if (if_b.bin_out !== 4'd14 || if_b.gray_out !== 4'b1001 || if_b.event_o !== 1'b0) begin
         failures++;
         $display("FAIL sat_leave_max: bin=%0d gray=%b ev=%b, need 14 1001 0", if_b.bin_out, if_b.gray_out, if_b.event_o);
      end
      if_b.en = 0; if_b.load = 1; if_b.load_gray = 4'b0000;
      tick();
      if_b.load = 0; if_b.en = 1; if_b.up_dn = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (if_b.bin_out !== 4'd0 || if_b.gray_out !== 4'b0000 || if_b.event_o !== 1'b1 || if_b.at_min !== 1'b1) begin
            failures++;
            $display("FAIL sat_min[%0d]: bin=%0d gray=%b ev=%b min=%b, need 0 0000 1 1",
                     i, if_b.bin_out, if_b.gray_out, if_b.event_o, if_b.at_min);
         end
      end
      if_b.up_dn = 1;
      tick();
      checks++;
      if (if_b.bin_out !== 4'd1 || if_b.gray_out !== 4'b0001 || if_b.event_o !== 1'b0) begin
         failures++;
         $display("FAIL sat_leave_min: bin=%0d gray=%b ev=%b, need 1 0001 0", if_b.bin_out, if_b.gray_out, if_b.event_o);
      end
      if_b.en = 0;
   endtask

   task automatic test_reset_mid();
      reset = 1; tick(); reset = 0;
      if_a.en = 1; if_a.up_dn = 1;
      repeat (6) tick();
      checks++;
      if (if_a.bin_out !== 4'd6 || if_a.gray_out !== 4'b0101) begin
         failures++;
         $display("FAIL mid_pre: bin=%0d gray=%b, need 6 0101", if_a.bin_out, if_a.gray_out);
      end
      reset = 1; if_a.load = 1; if_a.load_gray = 4'b1111;
      tick();
      checks++;
      if (if_a.bin_out !== 4'd0 || if_a.gray_out !== 4'b0000 || if_a.event_o !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: bin=%0d gray=%b ev=%b, need 0 0000 0", if_a.bin_out, if_a.gray_out, if_a.event_o);
      end
      reset = 0;
      idle_all();
   endtask

   task automatic test_random();
      logic [7:0] ref_bin;
      logic       ref_ev;
      logic [7:0] lg;
      reset = 1; tick(); reset = 0;
      ref_bin = 8'd0;
      for (int n = 0; n < 600; n++) begin
         if_c.en    = 1'($urandom_range(0, 3) != 0);
         if_c.up_dn = 1'($urandom_range(0, 1));
         if_c.load  = 1'($urandom_range(0, 15) == 0);
         lg         = 8'($urandom_range(0, 255));
         if_c.load_gray = lg;
         ref_ev = 1'b0;
         if (if_c.load) begin
            ref_bin = g2b8(lg);
         end else if (if_c.en) begin
            if (if_c.up_dn) begin
               ref_ev  = (ref_bin == 8'd255);
               ref_bin = ref_bin + 8'd1;
            end else begin
               ref_ev  = (ref_bin == 8'd0);
               ref_bin = ref_bin - 8'd1;
            end
         end
         tick();
         checks++;
         if (if_c.bin_out !== ref_bin || if_c.gray_out !== (ref_bin ^ (ref_bin >> 1)) || if_c.event_o !== ref_ev
`ifdef GRAY_STEP_CHECK_EN
             || if_c.step_err !== 1'b0
`endif
            ) begin
            failures++;
            $display("FAIL random[%0d]: bin=%0d gray=%h ev=%b, need bin=%0d gray=%h ev=%b",
                     n, if_c.bin_out, if_c.gray_out, if_c.event_o, ref_bin, ref_bin ^ (ref_bin >> 1), ref_ev);
         end
      end
      if_c.en = 0; if_c.load = 0;
   endtask

`ifdef GRAY_STEP_CHECK_EN
   task automatic test_step_err();
      reset = 1; tick(); reset = 0;
      if_c.en = 1; if_c.up_dn = 1;
      tick();
      if_c.en = 0;
      force dut_c.gray_q = 8'h03;
      tick();
      release dut_c.gray_q;
      checks++;
      if (if_c.step_err !== 1'b1) begin
         failures++;
         $display("FAIL step_err_set: step_err=%b, need 1", if_c.step_err);
      end
      if_c.en = 1;
      repeat (4) tick();
      checks++;
      if (if_c.step_err !== 1'b1) begin
         failures++;
         $display("FAIL step_err_sticky: step_err=%b, need 1", if_c.step_err);
      end
      if_c.en = 0;
      reset = 1; tick(); reset = 0;
      checks++;
      if (if_c.step_err !== 1'b0) begin
         failures++;
         $display("FAIL step_err_clear: step_err=%b, need 0", if_c.step_err);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      idle_all();
      reset = 1;
      tick();
      tick();
      test_reset();
      test_count_up();
      test_down_wrap();
      test_load();
      test_saturate();
      test_reset_mid();
      test_random();
`ifdef GRAY_STEP_CHECK_EN
      test_step_err();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
